ifft8_seq_core: RTL and testbench

//   8-point radix-2 DIT inverse FFT, time-multiplexed on one butterfly. Accepts one

---
 rtl/ifft8_seq_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_ifft8_seq_core.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_seq_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifft8_seq_core: 8-point radix-2 DIT inverse FFT on one shared butterfly.  |
// | Optional macro IFFT8_SCALE_EN: halve every butterfly result (1/8 total). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifft8_seq_core #(
    parameter int DW   = 24,
    parameter int TW   = 16,
    parameter int FRAC = 13
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_last,
    output logic          busy
);

    localparam int c_pw = DW + TW;
    localparam logic signed [TW-1:0] c_w_one = TW'(16'sh2000);
    localparam logic signed [TW-1:0] c_w_h   = TW'(16'sh16A0);
    localparam logic signed [TW-1:0] c_w_nh  = TW'(16'shE95F);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [DW-1:0]   bank_re_q [8];
    logic [DW-1:0]   bank_re_d [8];
    logic [DW-1:0]   bank_im_q [8];
    logic [DW-1:0]   bank_im_d [8];
    logic signed [c_pw-1:0] prod_re_q, prod_re_d;
    logic signed [c_pw-1:0] prod_im_q, prod_im_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   out_real_q, out_real_d;
    logic [DW-1:0]   out_imag_q, out_imag_d;

    // Butterfly addressing: cnt[4:3] = stage, cnt[2:1] = butterfly, cnt[0] = MUL/ADD phase
    logic [1:0] bk;
    logic [1:0] m_idx;
    logic [2:0] p_idx, q_idx;

    always_comb begin
        bk    = cnt_q[2:1];
        p_idx = 3'd0;
        q_idx = 3'd0;
        m_idx = 2'd0;
        case (cnt_q[4:3])
            2'd0: begin
                p_idx = {bk, 1'b0};
                q_idx = {bk, 1'b1};
            end
            2'd1: begin
                p_idx = {bk[1], 1'b0, bk[0]};
                q_idx = {bk[1], 1'b1, bk[0]};
                m_idx = {bk[0], 1'b0};
            end
            default: begin
                p_idx = {1'b0, bk};
                q_idx = {1'b1, bk};
                m_idx = bk;
            end
        endcase
    end

    logic signed [TW-1:0]   w_re, w_im;
    logic signed [c_pw-1:0] wr_x, wi_x, qr_x, qi_x;
    logic signed [c_pw-1:0] mul_re, mul_im;

    always_comb begin
        w_re = c_w_one;
        w_im = '0;
        case (m_idx)
            2'd1:    begin w_re = c_w_h;  w_im = c_w_h;   end
            2'd2:    begin w_re = '0;     w_im = c_w_one; end
            2'd3:    begin w_re = c_w_nh; w_im = c_w_h;   end
            default: begin w_re = c_w_one; w_im = '0;     end
        endcase
        wr_x   = {{DW{w_re[TW-1]}}, w_re};
        wi_x   = {{DW{w_im[TW-1]}}, w_im};
        qr_x   = {{TW{bank_re_q[q_idx][DW-1]}}, bank_re_q[q_idx]};
        qi_x   = {{TW{bank_im_q[q_idx][DW-1]}}, bank_im_q[q_idx]};
        mul_re = qr_x * wr_x - qi_x * wi_x;
        mul_im = qr_x * wi_x + qi_x * wr_x;
    end

    logic signed [DW:0]   t_re, t_im, p_re_x, p_im_x;
    logic signed [DW:0]   yp_re, yp_im, yq_re, yq_im;
    logic [DW-1:0]        rp_re, rp_im, rq_re, rq_im;

    always_comb begin
        t_re   = (DW+1)'(prod_re_q >>> FRAC);
        t_im   = (DW+1)'(prod_im_q >>> FRAC);
        p_re_x = {bank_re_q[p_idx][DW-1], bank_re_q[p_idx]};
        p_im_x = {bank_im_q[p_idx][DW-1], bank_im_q[p_idx]};
        yp_re  = p_re_x + t_re;
        yp_im  = p_im_x + t_im;
        yq_re  = p_re_x - t_re;
        yq_im  = p_im_x - t_im;
`ifdef IFFT8_SCALE_EN
        rp_re  = DW'(yp_re >>> 1);
        rp_im  = DW'(yp_im >>> 1);
        rq_re  = DW'(yq_re >>> 1);
        rq_im  = DW'(yq_im >>> 1);
`else
        rp_re  = DW'(yp_re);
        rp_im  = DW'(yp_im);
        rq_re  = DW'(yq_re);
        rq_im  = DW'(yq_im);
`endif
    end

    logic [2:0] ld_addr, nxt_out;
    assign ld_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};
    assign nxt_out = cnt_q[2:0] + 3'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_re_d   = bank_re_q;
        bank_im_d   = bank_im_q;
        prod_re_d   = prod_re_q;
        prod_im_d   = prod_im_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    bank_re_d[ld_addr] = in_real;
                    bank_im_d[ld_addr] = in_imag;
                    if (cnt_q == 5'd7) begin
                        cnt_d      = 5'd0;
                        state_d    = S_COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + 5'd1;
                if (!cnt_q[0]) begin
                    prod_re_d = mul_re;
                    prod_im_d = mul_im;
                end else begin
                    bank_re_d[p_idx] = rp_re;
                    bank_im_d[p_idx] = rp_im;
                    bank_re_d[q_idx] = rq_re;
                    bank_im_d[q_idx] = rq_im;
                end
                // The final butterfly never touches address 0, so bank_q[0] is settled here
                if (cnt_q == 5'd23) begin
                    cnt_d       = 5'd0;
                    state_d     = S_UNLOAD;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_real_d  = bank_re_q[0];
                    out_imag_d  = bank_im_q[0];
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_d       = 5'd0;
                        state_d     = S_LOAD;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        out_real_d  = '0;
                        out_imag_d  = '0;
                    end else begin
                        cnt_d      = {2'b00, nxt_out};
                        out_last_d = (nxt_out == 3'd7);
                        out_real_d = bank_re_q[nxt_out];
                        out_imag_d = bank_im_q[nxt_out];
                    end
                end
            end
            default: begin
                state_d     = S_LOAD;
                cnt_d       = 5'd0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_LOAD;
            cnt_q       <= 5'd0;
            prod_re_q   <= '0;
            prod_im_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                bank_re_q[i] <= '0;
                bank_im_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_re_q   <= prod_re_d;
            prod_im_q   <= prod_im_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            bank_re_q   <= bank_re_d;
            bank_im_q   <= bank_im_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft8_seq_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifft8_seq_core: self-checking bench for ifft8_seq_core.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ifft8_seq_core;

    localparam int DW = 24;
`ifdef IFFT8_SCALE_EN
    localparam longint c_s   = 1024;
    localparam longint c_h   = 724;
    localparam longint c_tol = 2;
`else
    localparam longint c_s   = 8192;
    localparam longint c_h   = 5793;
    localparam longint c_tol = 4;
`endif

    typedef longint frame_t [8];

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real, in_imag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_real, out_imag;
    logic          out_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    ifft8_seq_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain fixed-point DIT IFFT over arrays
    longint c_wr [4] = '{8192, 5792, 0, -5793};
    longint c_wi [4] = '{0, 5792, 8192, 5792};

    function automatic longint wrapn(input longint x, input int n);
        longint m;
        m = x & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1))) m = m - (longint'(1) << n);
        return m;
    endfunction

    function automatic longint fin(input longint y);
`ifdef IFFT8_SCALE_EN
        return wrapn(y >>> 1, DW);
`else
        return wrapn(y, DW);
`endif
    endfunction

    task automatic model(input frame_t xr, input frame_t xi, output frame_t yr, output frame_t yi);
        longint br [8];
        longint bi [8];
        for (int k = 0; k < 8; k++) begin
            int rk;
            rk = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            br[rk] = xr[k];
            bi[rk] = xi[k];
        end
        for (int s = 0; s < 3; s++) begin
            int h;
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    int p, q, m;
                    longint tr, ti, ypr, ypi, yqr, yqi;
                    p  = g + j;
                    q  = p + h;
                    m  = (j * 4) >> s;
                    tr = wrapn((br[q] * c_wr[m] - bi[q] * c_wi[m]) >>> 13, DW + 1);
                    ti = wrapn((br[q] * c_wi[m] + bi[q] * c_wr[m]) >>> 13, DW + 1);
                    ypr = wrapn(br[p] + tr, DW + 1);
                    ypi = wrapn(bi[p] + ti, DW + 1);
                    yqr = wrapn(br[p] - tr, DW + 1);
                    yqi = wrapn(bi[p] - ti, DW + 1);
                    br[p] = fin(ypr);
                    bi[p] = fin(ypi);
                    br[q] = fin(yqr);
                    bi[q] = fin(yqi);
                end
            end
        end
        yr = br;
        yi = bi;
    endtask

    // Monitor / scoreboard state
    longint exp_re_q[$];
    longint exp_im_q[$];
    frame_t in_br, in_bi;
    longint cap_re [8];
    longint cap_im [8];
    int     in_cnt = 0, mon_idx = 0, frames_done = 0;
    int     neg_cyc = 0, hs8_cyc = 0, rise_cyc = 0;
    logic   prev_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_re = '0, prev_im = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_re_q.delete();
            exp_im_q.delete();
            in_cnt     = 0;
            mon_idx    = 0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (in_ready === busy) begin
                failures++;
                $display("FAIL ready_vs_busy cyc=%0d in_ready=%b busy=%b (must differ)", neg_cyc, in_ready, busy);
            end
            if (in_valid && in_ready) begin
                in_br[in_cnt] = longint'($signed(in_real));
                in_bi[in_cnt] = longint'($signed(in_imag));
                in_cnt++;
                if (in_cnt == 8) begin
                    frame_t yr, yi;
                    model(in_br, in_bi, yr, yi);
                    for (int k = 0; k < 8; k++) begin
                        exp_re_q.push_back(yr[k]);
                        exp_im_q.push_back(yi[k]);
                    end
                    in_cnt  = 0;
                    hs8_cyc = neg_cyc;
                end
            end
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_real !== prev_re || out_imag !== prev_im || out_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_stable cyc=%0d got v=%b %0h/%0h l=%b held %0h/%0h l=%b",
                             neg_cyc, out_valid, out_real, out_imag, out_last, prev_re, prev_im, prev_last);
                end
            end
            if (out_valid) begin
                if (!prev_valid) rise_cyc = neg_cyc;
                checks++;
                if (exp_re_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_out_valid cyc=%0d got out_valid=1 expected 0", neg_cyc);
                end else begin
                    logic [DW-1:0] er, ei;
                    logic          el;
                    er = DW'(exp_re_q[0]);
                    ei = DW'(exp_im_q[0]);
                    el = (mon_idx == 7);
                    if (out_real !== er || out_imag !== ei) begin
                        failures++;
                        $display("FAIL out_data n=%0d got (%0d,%0d) expected (%0d,%0d)", mon_idx,
                                 $signed(out_real), $signed(out_imag), $signed(er), $signed(ei));
                    end
                    checks++;
                    if (out_last !== el) begin
                        failures++;
                        $display("FAIL out_last n=%0d got %b expected %b", mon_idx, out_last, el);
                    end
                    if (out_ready) begin
                        cap_re[mon_idx] = longint'($signed(out_real));
                        cap_im[mon_idx] = longint'($signed(out_imag));
                        void'(exp_re_q.pop_front());
                        void'(exp_im_q.pop_front());
                        mon_idx++;
                        if (mon_idx == 8) begin
                            mon_idx = 0;
                            frames_done++;
                        end
                    end
                end
            end
            prev_valid = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_re    = out_real;
            prev_im    = out_imag;
            prev_last  = out_last;
        end
        neg_cyc++;
    end

    // out_ready pattern: 0 = always, 1 = one cycle in three, 2 = random
    int ready_mode = 0;
    int rc = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = (rc % 3 == 0);
                2:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
            rc++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input frame_t r, input frame_t im, input bit gaps);
        bit hs;
        int guard;
        for (int k = 0; k < 8; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_real  = DW'(r[k]);
            in_imag  = DW'(im[k]);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 300) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) begin
                checks++;
                failures++;
                $display("FAIL in_handshake_timeout k=%0d got in_ready=0 expected 1", k);
            end
        end
        in_valid = 1'b0;
        in_real  = DW'($urandom);
        in_imag  = DW'($urandom);
    endtask

    task automatic wait_frames(input int target);
        int guard;
        guard = 0;
        while (frames_done < target && guard < 600) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (frames_done < target) begin
            failures++;
            $display("FAIL frame_timeout got frames=%0d expected %0d", frames_done, target);
        end
    endtask

    function automatic longint rnd_s();
`ifdef IFFT8_SCALE_EN
        return longint'($urandom_range(0, 16777214)) - 8388607;
`else
        return longint'($urandom_range(0, 2097150)) - 1048575;
`endif
    endfunction

    frame_t fr, fi;
    int     done;

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1, 0);
        chk("rst_out_valid", longint'(out_valid), 0, 0);
        chk("rst_out_last", longint'(out_last), 0, 0);
        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_out_real", longint'(out_real), 0, 0);
        chk("rst_out_imag", longint'(out_imag), 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Impulse at DC
        for (int k = 0; k < 8; k++) begin fr[k] = 0; fi[k] = 0; end
        fr[0] = 8192;
        send_frame(fr, fi, 1'b0);
        wait_frames(1);
        for (int n = 0; n < 8; n++) begin
            chk("t1_re", cap_re[n], c_s, 0);
            chk("t1_im", cap_im[n], 0, 0);
        end
        chk("t1_latency", longint'(rise_cyc - hs8_cyc), 25, 0);

        // Flat spectrum
        for (int k = 0; k < 8; k++) begin fr[k] = 1024; fi[k] = 0; end
        send_frame(fr, fi, 1'b0);
        wait_frames(2);
        chk("t2_x0_re", cap_re[0], c_s, 0);
        for (int n = 1; n < 8; n++) chk("t2_xn_re", cap_re[n], 0, 0);

        // Single bin k=1
        for (int k = 0; k < 8; k++) begin fr[k] = 0; fi[k] = 0; end
        fr[1] = 8192;
        send_frame(fr, fi, 1'b0);
        wait_frames(3);
        chk("t3_x0_re", cap_re[0], c_s, c_tol);
        chk("t3_x1_re", cap_re[1], c_h, c_tol);
        chk("t3_x1_im", cap_im[1], c_h, c_tol);
        chk("t3_x2_im", cap_im[2], c_s, c_tol);
        chk("t3_x4_re", cap_re[4], -c_s, c_tol);
        chk("t3_x6_im", cap_im[6], -c_s, c_tol);

        // Flat spectrum with back-pressure, input gaps and in_valid held while busy
        ready_mode = 1;
        for (int k = 0; k < 8; k++) begin fr[k] = 1024; fi[k] = 0; end
        send_frame(fr, fi, 1'b1);
        in_valid = 1'b1;
        repeat (16) begin
            in_real = DW'($urandom);
            in_imag = DW'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_frames(4);
        chk("t4_x0_re", cap_re[0], c_s, 0);
        chk("t4_x7_re", cap_re[7], 0, 0);
        ready_mode = 0;

        // Reset while presenting the 4th output sample
        for (int k = 0; k < 8; k++) begin fr[k] = 0; fi[k] = 0; end
        fr[0] = 8192;
        send_frame(fr, fi, 1'b0);
        ready_mode = 1;
        done = 0;
        for (int g = 0; g < 400 && done == 0; g++) begin
            @(negedge clk);
            #2;
            if (out_valid && mon_idx == 3) done = 1;
        end
        chk("t5_reached_4th", longint'(done), 1, 0);
        rstn = 1'b0;
        #1;
        chk("t5_rst_out_valid", longint'(out_valid), 0, 0);
        chk("t5_rst_in_ready", longint'(in_ready), 1, 0);
        chk("t5_rst_busy", longint'(busy), 0, 0);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_frame(fr, fi, 1'b0);
        wait_frames(5);
        for (int n = 0; n < 8; n++) chk("t5_re", cap_re[n], c_s, 0);
        chk("t5_latency", longint'(rise_cyc - hs8_cyc), 25, 0);

        // Random frames against the reference model
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) begin fr[k] = rnd_s(); fi[k] = rnd_s(); end
            send_frame(fr, fi, 1'b1);
            wait_frames(6 + f);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
